// File: rtl/tweet_pkg.sv
// Shared definitions for the tweet buffer: geometry, FSM encoding and
// the layout of a stored RAM word.
package tweet_pkg;

    // Geometry of the character store.
    localparam int TWEET_DEPTH = 256;
    localparam int TWEET_LIMIT = 160;

    // Bit 15 of a stored word marks the slot as occupied; the character
    // sits in the low byte and bits 14:8 are always written as zero.
    localparam int OCC_BIT = 15;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RD_HOLD = 3'd5
    } state_t;

    // Build the RAM word for an occupied slot holding ch.
    function automatic logic [15:0] make_word(input logic [7:0] ch);
        logic [15:0] w;
        w          = 16'h0000;
        w[OCC_BIT] = 1'b1;
        w[7:0]     = ch;
        return w;
    endfunction

endpackage

// File: rtl/tweet_ram_ctrl.sv
// Tweet buffer controller: appends/erases characters in an external
// single-port RAM, sweeps it clean on reset or request, and plays the
// stored text back over a valid/ready handshake.
module tweet_ram_ctrl
    import tweet_pkg::*;
#(
    parameter int DEPTH = TWEET_DEPTH,
    parameter int LIMIT = TWEET_LIMIT
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        clr_req,
    input  logic        wr_req,
    input  logic [7:0]  wr_char,
    input  logic        bs_req,
    output logic        wr_ack,
    output logic        wr_drop,
    input  logic        rd_start,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_char,
    output logic        rd_done,
    output logic        busy,
    output logic        full,
    output logic [7:0]  len,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
    localparam logic [7:0] LIMIT_LEN = 8'(LIMIT);

    // FSM and bookkeeping state.
    state_t      state_q,      state_d;
    logic [7:0]  sweep_addr_q, sweep_addr_d;
    logic [7:0]  len_q,        len_d;
    logic [7:0]  rd_ptr_q,     rd_ptr_d;
    logic        occ_q,        occ_d;

    // Registered outputs.
    logic [7:0]  rd_char_q,    rd_char_d;
    logic        wr_ack_q,     wr_ack_d;
    logic        wr_drop_q,    wr_drop_d;
    logic        rd_valid_q,   rd_valid_d;
    logic        rd_done_q,    rd_done_d;
    logic        busy_q,       busy_d;
    logic        ram_we_q,     ram_we_d;
    logic [7:0]  ram_addr_q,   ram_addr_d;
    logic [15:0] ram_wdata_q,  ram_wdata_d;

    logic [7:0]  next_ptr;

    // Only the occupied flag and the character byte of a read word matter.
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^ram_rdata[14:8];

    // Next-state and next-output decode; clr_req overrides everything
    // except an in-progress sweep.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        len_d        = len_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        rd_char_d    = rd_char_q;
        wr_ack_d     = 1'b0;
        wr_drop_d    = 1'b0;
        rd_valid_d   = 1'b0;
        rd_done_d    = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = 16'h0000;
        next_ptr     = rd_ptr_q + 8'd1;

        if (state_q != ST_CLEAR && clr_req) begin
            state_d      = ST_CLEAR;
            sweep_addr_d = 8'd0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // One zero word per cycle; the strobe for sweep_addr_q
                    // appears on the bus in the following cycle.
                    ram_we_d    = 1'b1;
                    ram_addr_d  = sweep_addr_q;
                    ram_wdata_d = 16'h0000;
                    len_d       = 8'd0;
                    if (sweep_addr_q == LAST_ADDR) begin
                        sweep_addr_d = 8'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        sweep_addr_d = sweep_addr_q + 8'd1;
                    end
                end

                ST_IDLE: begin
                    if (bs_req) begin
                        state_d  = ST_WRITE;
                        wr_ack_d = 1'b1;
                        if (len_q != 8'd0) begin
                            ram_we_d    = 1'b1;
                            ram_addr_d  = len_q - 8'd1;
                            ram_wdata_d = 16'h0000;
                            len_d       = len_q - 8'd1;
                        end
                    end else if (wr_req) begin
                        state_d  = ST_WRITE;
                        wr_ack_d = 1'b1;
                        if (len_q < LIMIT_LEN) begin
                            ram_we_d    = 1'b1;
                            ram_addr_d  = len_q;
                            ram_wdata_d = make_word(wr_char);
                            len_d       = len_q + 8'd1;
                        end else begin
                            wr_drop_d = 1'b1;
                        end
                    end else if (rd_start) begin
                        if (len_q == 8'd0) begin
                            rd_done_d = 1'b1;
                        end else begin
                            state_d    = ST_RD_ADDR;
                            rd_ptr_d   = 8'd0;
                            ram_addr_d = 8'd0;
                        end
                    end
                end

                ST_WRITE: begin
                    // Gives the requester a cycle to drop its request.
                    state_d = ST_IDLE;
                end

                ST_RD_ADDR: begin
                    // Address is on the bus; RAM data arrives next cycle.
                    state_d = ST_RD_DATA;
                end

                ST_RD_DATA: begin
                    occ_d      = ram_rdata[OCC_BIT];
                    rd_char_d  = ram_rdata[7:0];
                    rd_valid_d = 1'b1;
                    state_d    = ST_RD_HOLD;
                end

                ST_RD_HOLD: begin
                    if (rd_ready) begin
                        rd_ptr_d = next_ptr;
                        if (next_ptr == len_q || !occ_q) begin
                            rd_done_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            ram_addr_d = next_ptr;
                            state_d    = ST_RD_ADDR;
                        end
                    end else begin
                        rd_valid_d = 1'b1;
                    end
                end

                default: begin
                    state_d      = ST_CLEAR;
                    sweep_addr_d = 8'd0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset into a fresh sweep.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            sweep_addr_q <= 8'd0;
            len_q        <= 8'd0;
            rd_ptr_q     <= 8'd0;
            occ_q        <= 1'b0;
            rd_char_q    <= 8'd0;
            wr_ack_q     <= 1'b0;
            wr_drop_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            busy_q       <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 8'd0;
            ram_wdata_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            len_q        <= len_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            rd_char_q    <= rd_char_d;
            wr_ack_q     <= wr_ack_d;
            wr_drop_q    <= wr_drop_d;
            rd_valid_q   <= rd_valid_d;
            rd_done_q    <= rd_done_d;
            busy_q       <= busy_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign wr_drop   = wr_drop_q;
    assign rd_valid  = rd_valid_q;
    assign rd_char   = rd_char_q;
    assign rd_done   = rd_done_q;
    assign busy      = busy_q;
    assign len       = len_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign full      = (len_q == LIMIT_LEN);

endmodule

// File: tb/tb_tweet_ram_ctrl.sv
// Directed bench for tweet_ram_ctrl with a behavioural registered-read RAM.
module tb_tweet_ram_ctrl;

    logic        sysclk = 1'b0;
    logic        reset, clr_req, wr_req, bs_req, rd_start, rd_ready;
    logic [7:0]  wr_char;
    logic        wr_ack, wr_drop, rd_valid, rd_done, busy, full, ram_we;
    logic [7:0]  rd_char, len, ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    logic [15:0] mem [0:255];
    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 sysclk = ~sysclk;

    tweet_ram_ctrl #(.DEPTH(256), .LIMIT(160)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .clr_req  (clr_req),
        .wr_req   (wr_req),
        .wr_char  (wr_char),
        .bs_req   (bs_req),
        .wr_ack   (wr_ack),
        .wr_drop  (wr_drop),
        .rd_start (rd_start),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_char  (rd_char),
        .rd_done  (rd_done),
        .busy     (busy),
        .full     (full),
        .len      (len),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // RAM model: write-enable plus one-cycle registered read.
    always @(posedge sysclk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (rd_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Issue one append (bs=0) or backspace (bs=1) and capture the ack cycle.
    task automatic do_req(input logic bs, input logic [7:0] ch,
                          output logic got_ack, output logic drop, output logic we,
                          output logic [7:0] addr, output logic [15:0] wdata,
                          output logic [7:0] len_at_ack);
        got_ack = 1'b0; drop = 1'b0; we = 1'b0;
        addr = 8'd0; wdata = 16'd0; len_at_ack = 8'd0;
        wr_char = ch;
        if (bs) bs_req = 1'b1; else wr_req = 1'b1;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            tick();
            if (wr_ack === 1'b1) begin
                got_ack = 1'b1; drop = wr_drop; we = ram_we;
                addr = ram_addr; wdata = ram_wdata; len_at_ack = len;
            end
        end
        wr_req = 1'b0;
        bs_req = 1'b0;
        $display("[TB] %s ch=%02h ack=%0b drop=%0b we=%0b addr=%0d wdata=%04h len=%0d",
                 bs ? "bksp  " : "append", ch, got_ack, drop, we, addr, wdata, len_at_ack);
    endtask

    // Pulse clr_req and wait (bounded) for the sweep to finish.
    task automatic do_clear(output logic ok);
        ok = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (busy === 1'b0) ok = 1'b1;
        end
        tick();
        $display("[TB] clear done=%0b len=%0d", ok, len);
    endtask

    task automatic write_str(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input int n);
        logic a, d, w;
        logic [7:0] ad, l;
        logic [15:0] wd;
        logic [7:0] chars [3];
        chars[0] = c0; chars[1] = c1; chars[2] = c2;
        for (int i = 0; i < n; i++) do_req(1'b0, chars[i], a, d, w, ad, wd, l);
        tick();
    endtask

    task automatic test_reset();
        int bad;
        int first_bad;
        reset = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (busy !== 1'b1 || ram_we !== 1'b0 || wr_ack !== 1'b0 || rd_valid !== 1'b0 ||
            len !== 8'd0 || rd_done !== 1'b0 || ram_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b we=%b ack=%b valid=%b len=%0d done=%b wdata=%h, required busy=1 others 0",
                     busy, ram_we, wr_ack, rd_valid, len, rd_done, ram_wdata);
        end
        reset = 1'b0;
        bad = 0; first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (busy !== 1'b1) begin bad++; if (first_bad < 0) first_bad = i; end
            tick();
            if (ram_we !== 1'b1 || ram_addr !== 8'(i) || ram_wdata !== 16'h0) begin
                bad++; if (first_bad < 0) first_bad = i;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_sweep: %0d bad cycles, first at step %0d, required 256 writes of 0 at 0..255 while busy",
                     bad, first_bad);
        end
        n_tests++;
        if (busy !== 1'b0 || len !== 8'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b len=%0d full=%b, required busy=0 len=0 full=0", busy, len, full);
        end
        tick();
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 16'h0) bad++;
        n_tests++;
        if (ram_we !== 1'b0 || bad != 0) begin
            n_fail++;
            $display("FAIL reset_ram: we=%b nonzero_words=%0d, required we=0 and 0 nonzero", ram_we, bad);
        end
    endtask

    task automatic test_append();
        logic a, d, w;
        logic [7:0] ad, l;
        logic [15:0] wd;
        do_req(1'b0, 8'h48, a, d, w, ad, wd, l);
        n_tests++;
        if (!(a === 1'b1 && d === 1'b0 && w === 1'b1 && ad === 8'd0 && wd === 16'h8048 && l === 8'd1)) begin
            n_fail++;
            $display("FAIL append_H: ack=%b drop=%b we=%b addr=%0d wdata=%h len=%0d, required 1 0 1 0 8048 1",
                     a, d, w, ad, wd, l);
        end
        do_req(1'b0, 8'h69, a, d, w, ad, wd, l);
        n_tests++;
        if (!(a === 1'b1 && d === 1'b0 && w === 1'b1 && ad === 8'd1 && wd === 16'h8069 && l === 8'd2)) begin
            n_fail++;
            $display("FAIL append_i: ack=%b drop=%b we=%b addr=%0d wdata=%h len=%0d, required 1 0 1 1 8069 2",
                     a, d, w, ad, wd, l);
        end
        tick();
        n_tests++;
        if (len !== 8'd2 || mem[0] !== 16'h8048 || mem[1] !== 16'h8069 || wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL append_ram: len=%0d ram0=%h ram1=%h ack=%b, required 2 8048 8069 0",
                     len, mem[0], mem[1], wr_ack);
        end
    endtask

    task automatic test_full();
        logic a, d, w, ok;
        logic [7:0] ad, l;
        logic [15:0] wd;
        int bad;
        do_clear(ok);
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            do_req(1'b0, 8'(32 + (i % 90)), a, d, w, ad, wd, l);
            if (!(a === 1'b1 && d === 1'b0 && w === 1'b1 && ad === 8'(i) && l === 8'(i + 1))) bad++;
        end
        tick();
        n_tests++;
        if (!ok || bad != 0 || len !== 8'd160 || full !== 1'b1 || mem[159] !== 16'h8065) begin
            n_fail++;
            $display("FAIL fill_160: clear_ok=%b bad=%0d len=%0d full=%b ram159=%h, required 1 0 160 1 8065",
                     ok, bad, len, full, mem[159]);
        end
        do_req(1'b0, 8'h7A, a, d, w, ad, wd, l);
        n_tests++;
        if (!(a === 1'b1 && d === 1'b1 && w === 1'b0 && l === 8'd160)) begin
            n_fail++;
            $display("FAIL append_full: ack=%b drop=%b we=%b len=%0d, required 1 1 0 160", a, d, w, l);
        end
        tick();
        n_tests++;
        if (len !== 8'd160 || full !== 1'b1 || wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: len=%0d full=%b drop=%b, required 160 1 0", len, full, wr_drop);
        end
    endtask

    task automatic test_backspace();
        logic a, d, w, ok;
        logic [7:0] ad, l;
        logic [15:0] wd;
        do_clear(ok);
        write_str(8'h78, 8'h79, 8'h7A, 3);
        do_req(1'b1, 8'h00, a, d, w, ad, wd, l);
        n_tests++;
        if (!(ok && a === 1'b1 && d === 1'b0 && w === 1'b1 && ad === 8'd2 && wd === 16'h0 && l === 8'd2)) begin
            n_fail++;
            $display("FAIL bksp_len3: ack=%b drop=%b we=%b addr=%0d wdata=%h len=%0d, required 1 0 1 2 0000 2",
                     a, d, w, ad, wd, l);
        end
        tick();
        n_tests++;
        if (mem[2] !== 16'h0 || mem[1] !== 16'h8079 || len !== 8'd2) begin
            n_fail++;
            $display("FAIL bksp_ram: ram2=%h ram1=%h len=%0d, required 0000 8079 2", mem[2], mem[1], len);
        end
        do_clear(ok);
        do_req(1'b1, 8'h00, a, d, w, ad, wd, l);
        tick();
        n_tests++;
        if (!(ok && a === 1'b1 && d === 1'b0 && w === 1'b0 && l === 8'd0 && len === 8'd0)) begin
            n_fail++;
            $display("FAIL bksp_empty: ack=%b drop=%b we=%b len_at_ack=%0d len=%0d, required 1 0 0 0 0",
                     a, d, w, l, len);
        end
    endtask

    task automatic test_empty_read();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        n_tests++;
        if (rd_done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read: done=%b busy=%b valid=%b, required 1 0 0", rd_done, busy, rd_valid);
        end
        tick();
        n_tests++;
        if (rd_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read_pulse: done=%b busy=%b, required 0 0", rd_done, busy);
        end
    endtask

    task automatic test_playback();
        logic ok, v1, v2, v3;
        logic [7:0] got [3];
        logic [7:0] want [3];
        int stall_bad, done_before;
        want[0] = 8'h61; want[1] = 8'h62; want[2] = 8'h63;
        do_clear(ok);
        write_str(8'h61, 8'h62, 8'h63, 3);
        done_before = done_cnt;
        stall_bad = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        v1 = rd_valid; tick();
        v2 = rd_valid; tick();
        v3 = rd_valid;
        n_tests++;
        if (!(ok && v1 === 1'b0 && v2 === 1'b0 && v3 === 1'b1)) begin
            n_fail++;
            $display("FAIL first_valid_latency: valid at +1,+2,+3 = %b%b%b, required 001", v1, v2, v3);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10 && rd_valid !== 1'b1; i++) tick();
            for (int s = 0; s < 5; s++) begin
                tick();
                if (rd_valid !== 1'b1) stall_bad++;
            end
            got[k] = rd_char;
            $display("[TB] read char %0d = %02h", k, got[k]);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            n_tests++;
            if (got[k] !== want[k]) begin
                n_fail++;
                $display("FAIL read_char%0d: got %02h, required %02h", k, got[k], want[k]);
            end
        end
        n_tests++;
        if (rd_done !== 1'b1 || rd_valid !== 1'b0 || stall_bad != 0) begin
            n_fail++;
            $display("FAIL read_end: done=%b valid=%b stall_bad=%0d, required 1 0 0", rd_done, rd_valid, stall_bad);
        end
        tick(); tick(); tick();
        n_tests++;
        if (done_cnt - done_before != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done_once: done pulses=%0d busy=%b, required 1 0", done_cnt - done_before, busy);
        end
    endtask

    task automatic test_clear_during_read();
        logic ok;
        int acks, we_cnt, done_before;
        logic fin;
        do_clear(ok);
        write_str(8'h78, 8'h79, 8'h00, 2);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 10 && rd_valid !== 1'b1; i++) tick();
        n_tests++;
        if (!ok || rd_valid !== 1'b1 || rd_char !== 8'h78) begin
            n_fail++;
            $display("FAIL clr_read_setup: ok=%b valid=%b char=%02h, required 1 1 78", ok, rd_valid, rd_char);
        end
        acks = 0;
        wr_req = 1'b1; wr_char = 8'h7A;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_ack === 1'b1) acks++;
        end
        wr_req = 1'b0;
        n_tests++;
        if (acks != 0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_held_off: acks=%0d valid=%b, required 0 1", acks, rd_valid);
        end
        done_before = done_cnt;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_abort: valid=%b busy=%b, required 0 1", rd_valid, busy);
        end
        we_cnt = 0; fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            tick();
            if (ram_we === 1'b1) we_cnt++;
            if (busy === 1'b0) fin = 1'b1;
        end
        tick();
        $display("[TB] clear during read: sweep writes=%0d", we_cnt);
        n_tests++;
        if (!fin || we_cnt != 256 || len !== 8'd0 || done_cnt != done_before ||
            mem[0] !== 16'h0 || mem[1] !== 16'h0) begin
            n_fail++;
            $display("FAIL clr_sweep: fin=%b writes=%0d len=%0d done_pulses=%0d ram0=%h ram1=%h, required 1 256 0 0 0 0",
                     fin, we_cnt, len, done_cnt - done_before, mem[0], mem[1]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clr_req = 1'b0; wr_req = 1'b0; bs_req = 1'b0;
        rd_start = 1'b0; rd_ready = 1'b0; wr_char = 8'h00;
        test_reset();
        test_append();
        test_full();
        test_backspace();
        test_empty_read();
        test_playback();
        test_clear_during_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tweet_ram_ctrl.md
TWEET_RAM_CTRL -- requirements
Module: tweet_ram_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, default 256, number of RAM words; LIMIT, default 160, maximum stored characters.
REQ-002 sysclk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 clr_req  in  1  level request to erase the whole buffer.
REQ-005 wr_req  in  1  append request; held until wr_ack.
REQ-006 wr_char  in  8  character to append; stable while wr_req is high.
REQ-007 bs_req  in  1  backspace request; held until wr_ack.
REQ-008 wr_ack  out  1  one-cycle pulse completing a wr_req or bs_req.
REQ-009 wr_drop  out  1  one-cycle pulse coincident with wr_ack when an append is rejected because the buffer is full.
REQ-010 rd_start  in  1  playback start; sampled only in IDLE.
REQ-011 rd_valid  out  1  rd_char holds a character for the transmitter.
REQ-012 rd_ready  in  1  transmitter accepts rd_char.
REQ-013 rd_char  out  8  playback character.
REQ-014 rd_done  out  1  one-cycle pulse at normal end of playback.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 full  out  1  high when len == LIMIT.
REQ-017 len  out  8  number of stored characters.
REQ-018 ram_we  out  1  RAM write strobe.
REQ-019 ram_addr  out  8  RAM address.
REQ-020 ram_wdata  out  16  RAM write word.
REQ-021 ram_rdata  in  16  RAM read word; valid one cycle after ram_addr.

Function
REQ-022 Stored word format SHALL be {1'b1, 7'b0, char}; bit 15 is the occupied flag, and an all-zero word means empty.
REQ-023 FSM states SHALL be CLEAR, IDLE, WRITE, RD_ADDR, RD_DATA and RD_HOLD.
REQ-024 CLEAR SHALL write 16'h0000 to addresses 0..DEPTH-1 at one per cycle (DEPTH cycles), set len=0, then enter IDLE.
REQ-025 clr_req SHALL take priority in every non-CLEAR state: an active read aborts with rd_valid=0 and no rd_done, and the FSM enters CLEAR the next cycle.
REQ-026 IDLE priority SHALL be clr_req > bs_req > wr_req > rd_start.
REQ-027 Append, len<LIMIT: next cycle (WRITE) ram_we=1, ram_addr=len, ram_wdata={1,7'b0,wr_char}, wr_ack=1; len increments in the same cycle.
REQ-028 Append, len==LIMIT: next cycle wr_ack=1, wr_drop=1, ram_we=0, len unchanged.
REQ-029 Backspace, len>0: next cycle ram_we=1, ram_addr=len-1, ram_wdata=0, wr_ack=1, and len decrements.
REQ-030 Backspace, len==0: next cycle wr_ack=1, no write, len stays 0 (no wrap).
REQ-031 Every WRITE visit SHALL return to IDLE after one cycle.
REQ-032 rd_start with len==0 SHALL pulse rd_done the next cycle and remain in IDLE.
REQ-033 rd_start with len>0 SHALL set rd_ptr=0 and enter RD_ADDR (ram_addr=rd_ptr), then RD_DATA (capture ram_rdata), then RD_HOLD.
REQ-034 In RD_HOLD, rd_valid SHALL be 1 and rd_char=captured[7:0]; the first rd_valid SHALL occur exactly 3 cycles after rd_start is sampled.
REQ-035 In RD_HOLD with rd_ready=1, rd_ptr SHALL increment; if the new rd_ptr==len, or the captured bit15==0, the block pulses rd_done and enters IDLE, else it returns to RD_ADDR.
REQ-036 wr_req and bs_req arriving during a read SHALL be held off (no wr_ack) until IDLE.
REQ-037 rd_start outside IDLE SHALL be ignored.
REQ-038 full SHALL be combinational from len; all other outputs SHALL be registered.
REQ-039 len arithmetic SHALL be 8-bit and never exceed LIMIT or go below 0.

Reset
REQ-040 reset SHALL force state CLEAR with sweep address 0, len=0, rd_ptr=0, and wr_ack, wr_drop, rd_valid, rd_done, ram_we, ram_wdata and rd_char all 0; busy SHALL be 1.
REQ-041 A reset asserted mid-operation SHALL abort it with no ack or done pulse and restart the full sweep.

Structure
REQ-042 DEPTH, LIMIT, the state encodings and the occupied-flag bit position SHALL live in the shared tweet package.
REQ-043 The block SHALL be a single module with no sub-modules; it connects to the existing ram and cereal instances.

Verification
REQ-044 Bench SHALL check: reset -> busy=1 for 256 cycles with ram_we=1 at addresses 0..255, wdata=0, then IDLE with len=0.
REQ-045 Bench SHALL check: append 'H','i' -> RAM[0]=16'h8048, RAM[1]=16'h8069, len=2, two wr_ack pulses, no wr_drop.
REQ-046 Bench SHALL check: append 161 chars -> len=160, full=1, and the 161st ack carries wr_drop=1 with no ram_we.
REQ-047 Bench SHALL check: len=3 then bs_req -> RAM[2]=0, len=2; bs_req at len=0 -> wr_ack only, len stays 0.
REQ-048 Bench SHALL check: "abc" stored, rd_start with rd_ready stalled 5 cycles per char -> rd_char sequence 61,62,63, rd_done once, first rd_valid 3 cycles after rd_start.
REQ-049 Bench SHALL check: clr_req during RD_HOLD -> rd_valid drops the next cycle, no rd_done, full 256-cycle sweep, len=0.
